// File: rtl/instr_loader.sv
// Program loader: assembles a little-endian byte stream into 32-bit words and writes them
// to instruction memory while holding the CPU. Optional checksum byte: INSTR_LOADER_CHECKSUM_EN.
module instr_loader #(
  parameter int ADDR_W = 7,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load_start,
  input  logic [ADDR_W-1:0] load_base,
  input  logic [ADDR_W:0]   load_len,
  input  logic              in_valid,
  input  logic [7:0]        in_data,
  output logic              in_ready,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              busy,
  output logic              done,
  output logic              cpu_hold,
  output logic              chk_err
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_RECV  = 3'd1,
    S_WRITE = 3'd2,
    S_CHECK = 3'd3,
    S_DONE  = 3'd4
  } state_e;

  localparam logic [ADDR_W:0] MAX_LEN = {1'b1, {ADDR_W{1'b0}}};

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [ADDR_W:0]     cnt_q, cnt_d;
  logic [1:0]          byte_q, byte_d;
  logic [DATA_W-1:0]   word_q, word_d;
`ifdef INSTR_LOADER_CHECKSUM_EN
  logic [7:0]          csum_q, csum_d;
  logic                chk_err_q, chk_err_d;
`endif

  // NOTE: every next-state signal gets its hold value first so no path can infer a latch.
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    cnt_d   = cnt_q;
    byte_d  = byte_q;
    word_d  = word_q;
`ifdef INSTR_LOADER_CHECKSUM_EN
    csum_d    = csum_q;
    chk_err_d = chk_err_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (load_start) begin
          addr_d  = load_base;
          cnt_d   = (load_len > MAX_LEN) ? MAX_LEN : load_len;
          byte_d  = 2'd0;
`ifdef INSTR_LOADER_CHECKSUM_EN
          csum_d    = 8'h00;
          chk_err_d = 1'b0;
`endif
          state_d = (load_len == '0) ? S_DONE : S_RECV;
        end
      end
      S_RECV: begin
        if (in_valid) begin
          word_d[8*int'(byte_q) +: 8] = in_data;
`ifdef INSTR_LOADER_CHECKSUM_EN
          csum_d = csum_q ^ in_data;
`endif
          byte_d = byte_q + 2'd1;
          if (byte_q == 2'd3) state_d = S_WRITE;
        end
      end
      S_WRITE: begin
        addr_d = addr_q + 1'b1;  // wraps naturally at 2^ADDR_W
        cnt_d  = cnt_q - 1'b1;
        if (cnt_q == {{ADDR_W{1'b0}}, 1'b1}) begin
`ifdef INSTR_LOADER_CHECKSUM_EN
          state_d = S_CHECK;
`else
          state_d = S_DONE;
`endif
        end else begin
          state_d = S_RECV;
        end
      end
`ifdef INSTR_LOADER_CHECKSUM_EN
      S_CHECK: begin
        if (in_valid) begin
          chk_err_d = (in_data != csum_q);
          state_d   = S_DONE;
        end
      end
`endif
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      addr_q  <= '0;
      cnt_q   <= '0;
      byte_q  <= '0;
      word_q  <= '0;
`ifdef INSTR_LOADER_CHECKSUM_EN
      csum_q    <= '0;
      chk_err_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      cnt_q   <= cnt_d;
      byte_q  <= byte_d;
      word_q  <= word_d;
`ifdef INSTR_LOADER_CHECKSUM_EN
      csum_q    <= csum_d;
      chk_err_q <= chk_err_d;
`endif
    end
  end

  // Outputs decode registered state only, so in_ready never depends on in_valid.
`ifdef INSTR_LOADER_CHECKSUM_EN
  assign in_ready = (state_q == S_RECV) || (state_q == S_CHECK);
  assign chk_err  = chk_err_q;
`else
  assign in_ready = (state_q == S_RECV);
  assign chk_err  = 1'b0;
`endif
  assign mem_we    = (state_q == S_WRITE);
  assign mem_addr  = addr_q;
  assign mem_wdata = word_q;
  assign busy      = (state_q != S_IDLE);
  assign cpu_hold  = (state_q != S_IDLE);
  assign done      = (state_q == S_DONE);

endmodule

// File: tb/tb_instr_loader.sv
// Self-checking bench for instr_loader: randomized byte streams compared against a
// word-level model of the expected memory writes and load timing.
`timescale 1ns/1ps
module tb_instr_loader;
  localparam int ADDR_W = 7;
  localparam int DATA_W = 32;
  localparam int DEPTH  = 1 << ADDR_W;
`ifdef INSTR_LOADER_CHECKSUM_EN
  localparam int CHK_EXTRA = 1;
`else
  localparam int CHK_EXTRA = 0;
`endif

  logic              clk = 1'b0;
  logic              rst;
  logic              load_start;
  logic [ADDR_W-1:0] load_base;
  logic [ADDR_W:0]   load_len;
  logic              in_valid;
  logic [7:0]        in_data;
  logic              in_ready, mem_we, busy, done, cpu_hold, chk_err;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;

  instr_loader #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .clk(clk), .rst(rst), .load_start(load_start), .load_base(load_base),
    .load_len(load_len), .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .busy(busy),
    .done(done), .cpu_hold(cpu_hold), .chk_err(chk_err)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;
  int start_cyc;
  always @(posedge clk) cyc++;

  typedef struct { int addr; logic [31:0] data; int cyc; } wr_t;
  wr_t         wr_q[$];
  logic [7:0]  stim[$];
  int          exp_addr[$];
  logic [31:0] exp_data[$];

  always @(negedge clk) if (mem_we === 1'b1) wr_q.push_back('{addr: int'(mem_addr), data: mem_wdata, cyc: cyc});

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Stream: nwords*4 random data bytes, plus the check byte when checksum support is built in.
  task automatic make_stim(input int nwords, input bit bad_chk);
    logic [7:0] x;
    x = 8'h00;
    stim.delete();
    for (int i = 0; i < 4 * nwords; i++) begin
      stim.push_back(8'($urandom));
      x ^= stim[i];
    end
    if (CHK_EXTRA == 1) stim.push_back(bad_chk ? (x ^ 8'h01) : x);
  endtask

  // Expected writes: word i goes to (base+i) mod DEPTH, bytes packed little-endian.
  task automatic build_model(input int base, input int len);
    int n;
    n = (len > DEPTH) ? DEPTH : len;
    exp_addr.delete();
    exp_data.delete();
    for (int i = 0; i < n; i++) begin
      exp_addr.push_back((base + i) % DEPTH);
      exp_data.push_back({stim[4*i+3], stim[4*i+2], stim[4*i+1], stim[4*i]});
    end
  endtask

  function automatic int wr_errors(output string info);
    int e;
    e = 0;
    info = "";
    if (wr_q.size() != exp_addr.size()) begin
      info = $sformatf("write count %0d, wanted %0d", wr_q.size(), exp_addr.size());
      e = 1;
    end else begin
      for (int i = 0; i < wr_q.size(); i++) begin
        if (wr_q[i].addr != exp_addr[i] || wr_q[i].data !== exp_data[i]) begin
          if (e == 0) info = $sformatf("write %0d got %0d:%h wanted %0d:%h",
                                       i, wr_q[i].addr, wr_q[i].data, exp_addr[i], exp_data[i]);
          e++;
        end
      end
    end
    return e;
  endfunction

  // mode: 0 continuous, 1 toggling, 2 random in_valid. done_k counts cycles after load_start.
  task automatic run_load(input int base, input int len, input int mode, input int collide_at,
                          output int done_k, output bit hold_ok, output int consumed);
    int  k;
    bit  v, acc;
    wr_q.delete();
    load_base  = ADDR_W'(base);
    load_len   = (ADDR_W+1)'(len);
    load_start = 1'b1;
    in_valid   = 1'b0;
    step();
    load_start = 1'b0;
    start_cyc  = cyc;
    k = 1; consumed = 0; hold_ok = 1'b1; done_k = -1;
    while (k < 4000) begin
      if (busy !== 1'b1 || cpu_hold !== 1'b1) hold_ok = 1'b0;
      if (done === 1'b1) begin
        done_k = k;
        break;
      end
      if (k == collide_at) begin
        load_start = 1'b1;
        load_base  = ADDR_W'(5);
        load_len   = (ADDR_W+1)'(1);
      end else begin
        load_start = 1'b0;
      end
      case (mode)
        0:       v = 1'b1;
        1:       v = (k % 2) == 1;
        default: v = $urandom_range(0, 1) == 1;
      endcase
      in_valid = v && (consumed < stim.size());
      in_data  = (consumed < stim.size()) ? stim[consumed] : 8'($urandom);
      acc = in_valid && (in_ready === 1'b1);
      step();
      k++;
      if (acc) consumed++;
    end
    in_valid   = 1'b0;
    load_start = 1'b0;
    step();
  endtask

  task automatic test_reset();
    logic [DATA_W+ADDR_W+5:0] outs;
    rst = 1'b1; load_start = 1'b0; load_base = '0; load_len = '0; in_valid = 1'b0; in_data = '0;
    step(); step();
    outs = {in_ready, mem_we, mem_addr, mem_wdata, busy, done, cpu_hold, chk_err};
    n_checks++;
    if (outs !== '0) $display("FAIL reset_values: got %h, wanted 0", outs); else n_pass++;
    rst = 1'b0;
    step();
  endtask

  task automatic test_reset_midload();
    logic [DATA_W+ADDR_W+5:0] outs;
    int dk, cons; bit hok; string info;
    wr_q.delete();
    load_base = 7'd0; load_len = 8'd2; load_start = 1'b1;
    step();
    load_start = 1'b0; in_valid = 1'b1; in_data = 8'hAA;
    step();
    in_data = 8'hBB;
    step();
    #2 rst = 1'b1;
    #1;
    outs = {in_ready, mem_we, mem_addr, mem_wdata, busy, done, cpu_hold, chk_err};
    n_checks++;
    if (outs !== '0) $display("FAIL midload_reset_values: got %h, wanted 0", outs); else n_pass++;
    step(); step();
    rst = 1'b0;
    for (int i = 0; i < 8; i++) step();
    in_valid = 1'b0;
    n_checks++;
    if (wr_q.size() != 0 || busy !== 1'b0)
      $display("FAIL midload_no_write: writes %0d busy %b, wanted 0 and 0", wr_q.size(), busy);
    else n_pass++;
    make_stim(1, 1'b0);
    build_model(3, 1);
    run_load(3, 1, 0, -1, dk, hok, cons);
    n_checks++;
    if (wr_errors(info) != 0) $display("FAIL reload_after_reset: %s", info); else n_pass++;
  endtask

  task automatic test_single_word();
    int dk, cons, wk; bit hok; string info;
    stim.delete();
    stim.push_back(8'h13); stim.push_back(8'h00); stim.push_back(8'h50); stim.push_back(8'h00);
    if (CHK_EXTRA == 1) stim.push_back(8'h43);
    build_model(0, 1);
    run_load(0, 1, 0, -1, dk, hok, cons);
    n_checks++;
    if (wr_errors(info) != 0) $display("FAIL single_word_data: %s", info); else n_pass++;
    wk = (wr_q.size() > 0) ? (wr_q[0].cyc - start_cyc + 1) : -1;
    n_checks++;
    if (wk != 5) $display("FAIL single_word_we_cycle: got t+%0d, wanted t+5", wk); else n_pass++;
    n_checks++;
    if (dk != 6 + CHK_EXTRA) $display("FAIL single_word_done: got t+%0d, wanted t+%0d", dk, 6 + CHK_EXTRA);
    else n_pass++;
    n_checks++;
    if (!hok) $display("FAIL single_word_hold: got hold gap, wanted continuous busy/cpu_hold"); else n_pass++;
    n_checks++;
    if (busy !== 1'b0 || cpu_hold !== 1'b0 || done !== 1'b0)
      $display("FAIL single_word_idle: got busy %b hold %b done %b, wanted 000", busy, cpu_hold, done);
    else n_pass++;
    n_checks++;
    if (chk_err !== 1'b0) $display("FAIL single_word_chk: got %b, wanted 0", chk_err); else n_pass++;
  endtask

  task automatic test_wrap();
    int dk, cons; bit hok; string info;
    make_stim(3, 1'b0);
    build_model(126, 3);
    run_load(126, 3, 0, -1, dk, hok, cons);
    n_checks++;
    if (wr_errors(info) != 0) $display("FAIL wrap_writes: %s", info); else n_pass++;
    n_checks++;
    if (dk != 16 + CHK_EXTRA) $display("FAIL wrap_done: got t+%0d, wanted t+%0d", dk, 16 + CHK_EXTRA);
    else n_pass++;
    stim.delete();
    exp_addr.delete(); exp_data.delete();
    run_load(40, 0, 0, -1, dk, hok, cons);
    n_checks++;
    if (dk != 1 || wr_q.size() != 0)
      $display("FAIL zero_len: got done t+%0d writes %0d, wanted t+1 and 0", dk, wr_q.size());
    else n_pass++;
  endtask

  task automatic test_backpressure();
    int dk, cons; bit hok; string info;
    make_stim(2, 1'b0);
    build_model(20, 2);
    run_load(20, 2, 1, -1, dk, hok, cons);
    n_checks++;
    if (wr_errors(info) != 0) $display("FAIL backpressure_writes: %s", info); else n_pass++;
    n_checks++;
    if (cons != stim.size()) $display("FAIL backpressure_bytes: got %0d, wanted %0d", cons, stim.size());
    else n_pass++;
  endtask

  task automatic test_collision();
    int dk, cons; bit hok; string info;
    make_stim(3, 1'b0);
    build_model(10, 3);
    run_load(10, 3, 0, 7, dk, hok, cons);
    n_checks++;
    if (wr_errors(info) != 0) $display("FAIL collision_writes: %s", info); else n_pass++;
    n_checks++;
    if (dk != 16 + CHK_EXTRA) $display("FAIL collision_done: got t+%0d, wanted t+%0d", dk, 16 + CHK_EXTRA);
    else n_pass++;
    step(); step();
    n_checks++;
    if (busy !== 1'b0) $display("FAIL collision_dropped: got busy %b, wanted 0", busy); else n_pass++;
  endtask

  task automatic test_clamp();
    int dk, cons, base; bit hok; string info;
    base = $urandom_range(0, DEPTH - 1);
    make_stim(DEPTH, 1'b0);
    build_model(base, 200);
    run_load(base, 200, 0, -1, dk, hok, cons);
    n_checks++;
    if (wr_errors(info) != 0) $display("FAIL clamp_writes: %s", info); else n_pass++;
    n_checks++;
    if (dk != 1 + 5 * DEPTH + CHK_EXTRA)
      $display("FAIL clamp_done: got t+%0d, wanted t+%0d", dk, 1 + 5 * DEPTH + CHK_EXTRA);
    else n_pass++;
  endtask

  task automatic test_idle_ignore();
    in_valid = 1'b1; in_data = 8'h5A;
    wr_q.delete();
    for (int i = 0; i < 5; i++) step();
    in_valid = 1'b0;
    n_checks++;
    if (busy !== 1'b0 || in_ready !== 1'b0 || wr_q.size() != 0)
      $display("FAIL idle_ignore: got busy %b ready %b writes %0d, wanted 0 0 0", busy, in_ready, wr_q.size());
    else n_pass++;
  endtask

  task automatic test_random();
    int dk, cons, base, len; bit hok; string info;
    for (int it = 0; it < 8; it++) begin
      base = $urandom_range(0, DEPTH - 1);
      len  = $urandom_range(1, 8);
      make_stim(len, 1'b0);
      build_model(base, len);
      run_load(base, len, 2, -1, dk, hok, cons);
      n_checks++;
      if (wr_errors(info) != 0) $display("FAIL random_%0d_writes: %s", it, info); else n_pass++;
      n_checks++;
      if (!hok || cons != stim.size())
        $display("FAIL random_%0d_flow: got hold %b bytes %0d, wanted 1 and %0d", it, hok, cons, stim.size());
      else n_pass++;
    end
  endtask

`ifdef INSTR_LOADER_CHECKSUM_EN
  task automatic test_checksum();
    int dk, cons; bit hok;
    stim.delete();
    stim.push_back(8'h01); stim.push_back(8'h02); stim.push_back(8'h03); stim.push_back(8'h04);
    stim.push_back(8'h04);
    run_load(0, 1, 0, -1, dk, hok, cons);
    n_checks++;
    if (chk_err !== 1'b0) $display("FAIL checksum_good: got %b, wanted 0", chk_err); else n_pass++;
    stim[4] = 8'h05;
    run_load(0, 1, 0, -1, dk, hok, cons);
    n_checks++;
    if (chk_err !== 1'b1) $display("FAIL checksum_bad: got %b, wanted 1", chk_err); else n_pass++;
    for (int i = 0; i < 4; i++) step();
    n_checks++;
    if (chk_err !== 1'b1) $display("FAIL checksum_held: got %b, wanted 1", chk_err); else n_pass++;
    load_base = '0; load_len = 8'd1; load_start = 1'b1;
    step();
    load_start = 1'b0;
    n_checks++;
    if (chk_err !== 1'b0) $display("FAIL checksum_cleared: got %b, wanted 0", chk_err); else n_pass++;
    rst = 1'b1; step(); rst = 1'b0; step();
  endtask
`endif

  initial begin
    test_reset();
    test_single_word();
    test_wrap();
    test_backpressure();
    test_collision();
    test_idle_ignore();
    test_clamp();
    test_random();
`ifdef INSTR_LOADER_CHECKSUM_EN
    test_checksum();
`endif
    test_reset_midload();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
